// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder
//   Reorders FFT output from bit-reversed to natural bin order using a
//   ping-pong pair of FFT_N x {re,im} banks. Each sample is written at
//   bitrev(wcnt) of the write bank. Completed frames are read out
//   sequentially. Fixed latency: the last sample accepted at cycle t
//   produces out_index k at cycle t+2+k.
//
//   Optional macro: FFT_REORDER_SOP_EN adds the out_sop/out_eop frame markers.
//
//   Ports:
//     clk, rst            rising-edge clock, synchronous active-high reset
//     in_valid/in_re/im   upstream samples in bit-reversed order
//     out_valid/re/im     natural-order samples
//     out_index           natural bin number of the current output
//     out_sop/out_eop     (FFT_REORDER_SOP_EN only) first/last bin markers
module fft_bitrev_reorder #(
  parameter  int FFT_N = 1024,
  localparam int LOG_N = $clog2(FFT_N)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic signed [15:0]      in_re,
  input  logic signed [15:0]      in_im,
  output logic                    out_valid,
  output logic signed [15:0]      out_re,
  output logic signed [15:0]      out_im,
  output logic        [LOG_N-1:0] out_index
`ifdef FFT_REORDER_SOP_EN
  ,
  output logic                    out_sop,
  output logic                    out_eop
`endif
);

  typedef enum logic {IDLE, READ} state_t;

  localparam logic [LOG_N-1:0] LAST = LOG_N'(FFT_N - 1);

  function automatic logic [LOG_N-1:0] bitrev(input logic [LOG_N-1:0] a);
    logic [LOG_N-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < LOG_N; i++) begin
      r[i] = a[LOG_N-1-i];
    end
    return r;
  endfunction

  // Both banks live in one array; the MSB of the address selects the bank.
  logic [31:0] mem [0:2*FFT_N-1];

  state_t            state_q, state_d;
  logic [LOG_N-1:0]  wcnt_q;
  logic              wsel_q;
  logic              rbank_q;
  logic [LOG_N-1:0]  raddr_q, raddr_d;

  logic              out_valid_q;
  logic signed [15:0] out_re_q, out_im_q;
  logic [LOG_N-1:0]  out_index_q;

  logic accept;
  logic frame_done;

  assign accept     = in_valid && !rst;
  assign frame_done = accept && (wcnt_q == LAST);

  // Write side: counter, bank select, storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt_q  <= '0;
      wsel_q  <= 1'b0;
      rbank_q <= 1'b0;
    end else if (accept) begin
      wcnt_q <= wcnt_q + LOG_N'(1);
      if (frame_done) begin
        wsel_q  <= ~wsel_q;
        rbank_q <= wsel_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[{wsel_q, bitrev(wcnt_q)}] <= {in_re, in_im};
    end
  end

  // Read FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      raddr_q <= '0;
    end else begin
      state_q <= state_d;
      raddr_q <= raddr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    raddr_d = raddr_q;
    case (state_q)
      IDLE: begin
        if (frame_done) begin
          state_d = READ;
          raddr_d = '0;
        end
      end
      READ: begin
        if (raddr_q == LAST) begin
          // A frame completing on the last read address chains straight
          // into the next read, which keeps back-to-back output gapless.
          raddr_d = '0;
          if (!frame_done) begin
            state_d = IDLE;
          end
        end else begin
          raddr_d = raddr_q + LOG_N'(1);
        end
      end
      default: begin
        state_d = IDLE;
        raddr_d = '0;
      end
    endcase
  end

  // Registered read port and output qualifiers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_index_q <= '0;
      out_re_q    <= '0;
      out_im_q    <= '0;
    end else begin
      out_valid_q <= (state_q == READ);
      if (state_q == READ) begin
        out_index_q          <= raddr_q;
        {out_re_q, out_im_q} <= mem[{rbank_q, raddr_q}];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;
  assign out_index = out_index_q;

`ifdef FFT_REORDER_SOP_EN
  logic out_sop_q, out_eop_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_sop_q <= 1'b0;
      out_eop_q <= 1'b0;
    end else begin
      out_sop_q <= (state_q == READ) && (raddr_q == '0);
      out_eop_q <= (state_q == READ) && (raddr_q == LAST);
    end
  end

  assign out_sop = out_sop_q;
  assign out_eop = out_eop_q;
`endif

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
module tb_fft_bitrev_reorder;

  localparam int N  = 8;
  localparam int LN = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic               in_valid;
  logic signed [15:0] in_re, in_im;
  logic               out_valid;
  logic signed [15:0] out_re, out_im;
  logic [LN-1:0]      out_index;
`ifdef FFT_REORDER_SOP_EN
  logic               out_sop, out_eop;
`endif

  fft_bitrev_reorder #(.FFT_N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_re    (in_re),
    .in_im    (in_im),
    .out_valid(out_valid),
    .out_re   (out_re),
    .out_im   (out_im),
    .out_index(out_index)
`ifdef FFT_REORDER_SOP_EN
    ,
    .out_sop  (out_sop),
    .out_eop  (out_eop)
`endif
  );

`ifdef FFT_REORDER_SOP_EN
  logic               vb;
  logic signed [15:0] reb;
  logic               ob_valid, ob_sop, ob_eop;
  logic signed [15:0] ob_re, ob_im;
  logic [9:0]         ob_idx;

  fft_bitrev_reorder #(.FFT_N(1024)) dut_big (
    .clk      (clk),
    .rst      (rst),
    .in_valid (vb),
    .in_re    (reb),
    .in_im    (16'sd0),
    .out_valid(ob_valid),
    .out_re   (ob_re),
    .out_im   (ob_im),
    .out_index(ob_idx),
    .out_sop  (ob_sop),
    .out_eop  (ob_eop)
  );
`endif

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic signed [15:0] re;
    logic signed [15:0] im;
    int                 idx;
    int                 t;
  } exp_t;

  exp_t               sb[$];
  logic signed [15:0] fr_re[N];
  logic signed [15:0] fr_im[N];
  int                 wc_m = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int brev(input int k, input int bits);
    int r = 0;
    for (int i = 0; i < bits; i++) r = (r << 1) | ((k >> i) & 1);
    return r;
  endfunction

  // Drive one cycle; the model captures accepted samples by arrival slot and
  // on frame completion queues the natural-order expectation with its cycle.
  task automatic drive(input bit v, input logic signed [15:0] re, input logic signed [15:0] im);
    in_valid = v;
    in_re    = re;
    in_im    = im;
    if (v) begin
      fr_re[wc_m] = re;
      fr_im[wc_m] = im;
      if (wc_m == N - 1) begin
        for (int k = 0; k < N; k++)
          sb.push_back('{fr_re[brev(k, LN)], fr_im[brev(k, LN)], k, cyc + 2 + k});
        wc_m = 0;
      end else begin
        wc_m++;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain(input string tag);
    int w = 0;
    in_valid = 1'b0;
    while (sb.size() > 0 && w < 60) begin @(posedge clk); #1; w++; end
    check(tag, 32'(sb.size()), 32'd0);
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  exp_t e;
  always @(negedge clk) begin
    if (out_valid) begin
      check("spurious_valid", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("out_re",    32'(out_re),    32'(e.re));
        check("out_im",    32'(out_im),    32'(e.im));
        check("out_index", 32'(out_index), 32'(e.idx));
        check("latency",   32'(cyc),       32'(e.t));
`ifdef FFT_REORDER_SOP_EN
        check("out_sop", 32'(out_sop), 32'(e.idx == 0));
        check("out_eop", 32'(out_eop), 32'(e.idx == N - 1));
`endif
      end
    end else if (sb.size() != 0 && sb[0].t <= cyc) begin
      check("missing_valid", 32'(out_valid), 32'd1);
      void'(sb.pop_front());
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_re = '0; in_im = '0;
`ifdef FFT_REORDER_SOP_EN
    vb = 1'b0; reb = '0;
`endif
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0; wc_m = 0;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_index", 32'(out_index), 32'd0);
    check("rst_re",    32'(out_re),    32'd0);
    check("rst_im",    32'(out_im),    32'd0);
    idle(3);

    // Single frame, ramp on re.
    for (int i = 0; i < N; i++) drive(1'b1, 16'(i), 16'sd0);
    drain("drain_single");
    idle(2);

    // Three back-to-back frames; exact-cycle checks imply a gapless stream.
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < N; i++)
        drive(1'b1, 16'(100 * f + i - 50), 16'(-(f * 8 + i)));
    drain("drain_b2b");
    idle(2);

    // Alternating valid gaps mid-frame.
    for (int i = 0; i < 2 * N; i++) drive(i % 2 == 0, 16'(30 + i / 2), 16'(i / 2));
    drain("drain_gaps");
    idle(2);

    // Partial frame discarded by reset; in_valid during reset is ignored.
    for (int i = 0; i < 5; i++) drive(1'b1, 16'(200 + i), 16'sd7);
    rst = 1'b1; in_valid = 1'b1; in_re = 16'sd99; in_im = 16'sd99;
    @(posedge clk); #1;
    rst = 1'b0; wc_m = 0; sb.delete();
    for (int i = 0; i < N; i++) drive(1'b1, 16'(10 + i), 16'sd0);
    drain("drain_after_rst");
    idle(2);

    // Reset while index 3 is on the output.
    for (int i = 0; i < N; i++) drive(1'b1, 16'(40 + i), 16'sd1);
    in_valid = 1'b0;
    for (int w = 0; w < 40; w++) begin
      if (out_valid && out_index == 3'd3) break;
      @(posedge clk); #1;
    end
    check("idx3_seen", 32'(out_valid && out_index == 3'd3), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; wc_m = 0; sb.delete();
    check("abort_index", 32'(out_index), 32'd0);
    check("abort_re",    32'(out_re),    32'd0);
    for (int w = 0; w < 12; w++) begin
      check("abort_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
    end

`ifdef FFT_REORDER_SOP_EN
    begin
      int seen = 0;
      for (int i = 0; i < 1024; i++) begin
        vb = 1'b1; reb = 16'(i);
        @(posedge clk); #1;
      end
      vb = 1'b0;
      for (int w = 0; w < 1100 && seen < 1024; w++) begin
        @(negedge clk);
        if (ob_valid) begin
          check("big_index", 32'(ob_idx), 32'(seen));
          check("big_sop",   32'(ob_sop), 32'(ob_idx == 10'd0));
          check("big_eop",   32'(ob_eop), 32'(ob_idx == 10'd1023));
          check("big_re",    32'(ob_re),  32'(brev(int'(ob_idx), 10)));
          if (ob_idx == 10'd1) check("big_re_idx1", 32'(ob_re), 32'd512);
          seen++;
        end
      end
      check("big_count", 32'(seen), 32'd1024);
      @(posedge clk); #1;
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_bitrev_reorder.md
FFT_BITREV_REORDER -- requirements
Module: fft_bitrev_reorder

Interface
REQ-001 SHALL have parameter FFT_N, default 1024, meaning the transform length; it must be a power of two and at least 4.
REQ-002 SHALL define localparam LOG_N = log2(FFT_N).
REQ-003 SHALL have port clk, input, width 1: rising-edge clock.
REQ-004 SHALL have port rst, input, width 1: reset, synchronous, active-high.
REQ-005 SHALL have port in_valid, input, width 1: qualifies one upstream FFT output sample per cycle.
REQ-006 SHALL have ports in_re and in_im, input, signed 16 each: upstream spectrum sample in bit-reversed bin order.
REQ-007 SHALL have port out_valid, output, width 1: qualifies out_re, out_im and out_index.
REQ-008 SHALL have ports out_re and out_im, output, signed 16 each: spectrum sample in natural bin order.
REQ-009 SHALL have port out_index, output, width LOG_N: natural bin number of the current output sample.

Function
REQ-010 SHALL hold two banks of FFT_N x 32-bit storage ({re,im}) as a ping-pong pair: one write bank and one read bank.
REQ-011 SHALL keep a LOG_N-bit write counter wcnt that advances by one on each accepted in_valid and wraps from FFT_N-1 to 0.
REQ-012 SHALL write each accepted sample at address bitrev(wcnt) of the write bank, where bitrev reverses the LOG_N bits.
REQ-013 SHALL treat the first in_valid after reset as bin slot 0 of a frame.
REQ-014 SHALL, on acceptance of the sample with wcnt = FFT_N-1, mark the frame complete, toggle the write-bank select, and start a read of the completed bank.
REQ-015 SHALL run the read FSM in states IDLE and READ. IDLE goes to READ on frame complete. READ issues read addresses 0..FFT_N-1, one per cycle. At the last address READ goes to IDLE, or stays in READ restarting at address 0 if another frame completes in that same cycle.
REQ-016 SHALL have a fixed latency: if the final sample of a frame is accepted at cycle t, the sample with out_index k is presented with out_valid=1 at cycle t+2+k.
REQ-017 SHALL hold out_valid low in every cycle without valid read data; out_re, out_im and out_index are don't-care while out_valid=0.
REQ-018 SHALL support back-to-back frames with in_valid held high continuously, producing a gapless out_valid stream with no lost or duplicated samples.
REQ-019 SHALL accept in_valid gaps of any length mid-frame; wcnt holds during gaps and no output is produced until the frame completes.
REQ-020 SHALL have no backpressure; downstream must always accept out_valid samples.
REQ-021 SHALL pass data through unmodified (no scaling, rounding or sign change).

Reset
REQ-022 SHALL, on rst=1 at a clock edge, clear wcnt, the bank select and the read address, set the FSM to IDLE, and drive out_valid=0, out_index=0, out_re=0 and out_im=0 from the next cycle.
REQ-023 SHALL discard any partially written frame and abort any in-progress read when rst asserts mid-operation; no out_valid is asserted after reset until a full new frame is written.
REQ-024 SHALL ignore in_valid in any cycle where rst=1.
REQ-025 SHALL NOT require the storage contents to be reset.

Configuration
REQ-026 SHALL recognise the macro FFT_REORDER_SOP_EN.
REQ-027 SHALL, when FFT_REORDER_SOP_EN is defined, add output ports out_sop (1 bit), high with out_valid at out_index=0, and out_eop (1 bit), high with out_valid at out_index=FFT_N-1; both reset to 0.
REQ-028 SHALL, when FFT_REORDER_SOP_EN is undefined, omit out_sop and out_eop, with all other behaviour unchanged.

Verification
REQ-029 SHALL be verified as follows. FFT_N=8, rst, then in_re=0..7 and in_im=0 on 8 consecutive in_valid cycles -> from t+2, out_re=0,4,2,6,1,5,3,7 with out_index=0..7.
REQ-030 SHALL be verified as follows. FFT_N=8, three frames streamed with in_valid held high -> 24 consecutive out_valid cycles, each frame reordered as in REQ-029, with no gap between frames.
REQ-031 SHALL be verified as follows. FFT_N=8, in_valid toggling 1,0,1,0,... for 16 cycles -> out_valid stays 0 until the 8th sample is accepted, then the same ordering as REQ-029.
REQ-032 SHALL be verified as follows. FFT_N=8, rst pulsed after 5 samples, then a full frame 10..17 -> output 10,14,12,16,11,15,13,17 and none of the pre-reset samples.
REQ-033 SHALL be verified as follows. FFT_N=8, rst pulsed during output of index 3 -> out_valid=0 from the next cycle and remains 0 with in_valid=0.
REQ-034 SHALL be verified as follows. With FFT_REORDER_SOP_EN defined, FFT_N=1024 and a ramp input -> out_sop is high exactly at out_index=0, out_eop exactly at out_index=1023, and out_re at index 1 equals 512.
